// File: rtl/uart_frame_assembler_if.sv
// Byte stream from uart_rx into the frame assembler.
// rx_done is a level; data and parity flag are valid while it is high.
interface uart_frame_assembler_if;
    logic       rx_done;
    logic [7:0] data_received;
    logic       parity_error;

    modport master (
        output rx_done,
        output data_received,
        output parity_error
    );

    modport slave (
        input rx_done,
        input data_received,
        input parity_error
    );
endinterface

// File: rtl/uart_frame_assembler.sv
// Receive-side framer: sync byte, XOR checksum, inter-byte timeout,
// atomic publication of complete multi-byte command words.
module uart_frame_assembler #(
    parameter int         NUM_BYTES      = 2,
    parameter bit         SYNC_EN        = 1'b0,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter bit         CHK_EN         = 1'b0,
    parameter int         TIMEOUT_CYCLES = 24000
) (
    input  logic                   clk,
    input  logic                   reset,
    uart_frame_assembler_if.slave  rx,
    output logic [8*NUM_BYTES-1:0] frame_data,
    output logic                   frame_valid,
    output logic                   busy,
    output logic                   err_parity,
    output logic                   err_checksum,
    output logic                   err_timeout,
    output logic [7:0]             err_count
);

    localparam int W  = 8 * NUM_BYTES;
    localparam int IW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO_LAST =
        CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BYTES - 1);

    typedef enum logic [1:0] {HUNT, DATA, CHK} state_t;

    state_t        state, state_d;
    logic [IW-1:0] idx, idx_d;
    logic [W-1:0]  stage, stage_d, stage_sh, frame_d;
    logic [7:0]    csum, csum_d;
    logic [CW-1:0] tcnt, tcnt_d;

    logic       rx_done_q;
    logic       evt_q;
    logic [7:0] byte_q;
    logic       perr_q;

    logic commit, drop_par, drop_chk, drop_to, drop_any;

    assign busy     = (state != HUNT);
    assign stage_sh = W'({stage, byte_q});
    assign drop_any = drop_par | drop_chk | drop_to;

    always_comb begin
        state_d  = state;
        idx_d    = idx;
        stage_d  = stage;
        csum_d   = csum;
        tcnt_d   = tcnt;
        commit   = 1'b0;
        drop_par = 1'b0;
        drop_chk = 1'b0;
        drop_to  = 1'b0;
        if (state != HUNT)
            tcnt_d = tcnt + CW'(1);
        if (evt_q) begin
            // a byte always beats a coincident timeout terminal count
            tcnt_d = '0;
            if (perr_q) begin
                if (!(state == HUNT && SYNC_EN))
                    drop_par = 1'b1;
            end else begin
                unique case (state)
                    HUNT: begin
                        if (SYNC_EN) begin
                            if (byte_q == SYNC_BYTE) begin
                                state_d = DATA;
                                idx_d   = '0;
                                csum_d  = '0;
                            end
                        end else begin
                            stage_d = stage_sh;
                            csum_d  = byte_q;
                            if (NUM_BYTES == 1) begin
                                if (CHK_EN) state_d = CHK;
                                else        commit  = 1'b1;
                            end else begin
                                state_d = DATA;
                                idx_d   = IW'(1);
                            end
                        end
                    end
                    DATA: begin
                        stage_d = stage_sh;
                        csum_d  = csum ^ byte_q;
                        if (idx == LAST_IDX) begin
                            if (CHK_EN) state_d = CHK;
                            else        commit  = 1'b1;
                        end else begin
                            idx_d = idx + IW'(1);
                        end
                    end
                    CHK: begin
                        if (byte_q == csum) commit   = 1'b1;
                        else                drop_chk = 1'b1;
                    end
                    default: state_d = HUNT;
                endcase
            end
        end else if (TIMEOUT_CYCLES > 0 && state != HUNT && tcnt == TO_LAST) begin
            drop_to = 1'b1;
        end
        frame_d = stage_d;
        if (commit || drop_any) begin
            state_d = HUNT;
            idx_d   = '0;
            tcnt_d  = '0;
            csum_d  = '0;
            stage_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_done_q    <= 1'b1;
            evt_q        <= 1'b0;
            byte_q       <= '0;
            perr_q       <= 1'b0;
            state        <= HUNT;
            idx          <= '0;
            stage        <= '0;
            csum         <= '0;
            tcnt         <= '0;
            frame_data   <= '0;
            frame_valid  <= 1'b0;
            err_parity   <= 1'b0;
            err_checksum <= 1'b0;
            err_timeout  <= 1'b0;
            err_count    <= '0;
        end else begin
            rx_done_q    <= rx.rx_done;
            evt_q        <= rx.rx_done & ~rx_done_q;
            byte_q       <= rx.data_received;
            perr_q       <= rx.parity_error;
            state        <= state_d;
            idx          <= idx_d;
            stage        <= stage_d;
            csum         <= csum_d;
            tcnt         <= tcnt_d;
            frame_valid  <= commit;
            err_parity   <= drop_par;
            err_checksum <= drop_chk;
            err_timeout  <= drop_to;
            if (commit)
                frame_data <= frame_d;
            if (drop_any && err_count != 8'hFF)
                err_count <= err_count + 8'd1;
        end
    end

endmodule
